// File: rtl/layer_ctrl_pwr_pkg.sv
// Shared types for the layer-controller power sequencer: state encoding and per-state output vectors.
// Isolation polarity comes from the shared IO_HOLD / IO_RELEASE defines; fallbacks apply if that file is absent.
`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif
`ifndef IO_RELEASE
`define IO_RELEASE 1'b0
`endif

package layer_ctrl_pwr_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_PWR_UP  = 4'd1,
        ST_CLK_ON  = 4'd2,
        ST_RST_REL = 4'd3,
        ST_ACTIVE  = 4'd4,
        ST_DRAIN   = 4'd5,
        ST_ISO_ON  = 4'd6,
        ST_RST_ON  = 4'd7,
        ST_PWR_DN  = 4'd8
    } pwr_state_e;

    typedef struct packed {
        logic sleep;
        logic clk_en;
        logic reset;
        logic iso;
    } pwr_out_t;

    localparam logic ISO_HOLD    = `IO_HOLD;
    localparam logic ISO_RELEASE = `IO_RELEASE;

    function automatic pwr_out_t state_outputs(input pwr_state_e s);
        pwr_out_t o;
        case (s)
            ST_PWR_UP:  o = '{sleep: 1'b0, clk_en: 1'b0, reset: 1'b1, iso: ISO_HOLD};
            ST_CLK_ON:  o = '{sleep: 1'b0, clk_en: 1'b1, reset: 1'b1, iso: ISO_HOLD};
            ST_RST_REL: o = '{sleep: 1'b0, clk_en: 1'b1, reset: 1'b0, iso: ISO_HOLD};
            ST_ACTIVE:  o = '{sleep: 1'b0, clk_en: 1'b1, reset: 1'b0, iso: ISO_RELEASE};
            ST_DRAIN:   o = '{sleep: 1'b0, clk_en: 1'b1, reset: 1'b0, iso: ISO_RELEASE};
            ST_ISO_ON:  o = '{sleep: 1'b0, clk_en: 1'b1, reset: 1'b0, iso: ISO_HOLD};
            ST_RST_ON:  o = '{sleep: 1'b0, clk_en: 1'b0, reset: 1'b1, iso: ISO_HOLD};
            default:    o = '{sleep: 1'b1, clk_en: 1'b0, reset: 1'b1, iso: ISO_HOLD};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/layer_ctrl_pwr_timer.sv
// Loadable down-counter for the power sequencer; done is high while the count sits at zero.
module layer_ctrl_pwr_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/layer_ctrl_power_seq.sv
// Layer-controller power sequencer: power gate, clock gate, reset and isolation ordering with drain on sleep.
// Optional DRAIN timeout enabled by defining LAYER_CTRL_PWR_TIMEOUT_EN.
module layer_ctrl_power_seq
    import layer_ctrl_pwr_pkg::*;
#(
    parameter int T_PWR     = 4,
    parameter int T_CLK     = 2,
    parameter int T_RST     = 2,
    parameter int T_ISO     = 1,
    parameter int DRAIN_TMO = 255,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wakeup_req,
    input  logic       sleep_req,
    input  logic       lc_busy,
    output logic       lc_sleep,
    output logic       lc_clk_en,
    output logic       lc_reset,
    output logic       lc_isolation,
    output logic       pwr_ack,
    output logic [3:0] pwr_state,
    output logic       timeout_flag
);

    localparam int MAX_T = (T_PWR > T_CLK ? T_PWR : T_CLK) > (T_RST > T_ISO ? T_RST : T_ISO)
                         ? (T_PWR > T_CLK ? T_PWR : T_CLK) : (T_RST > T_ISO ? T_RST : T_ISO);
    localparam int MAX_LOAD = (MAX_T > DRAIN_TMO ? MAX_T : DRAIN_TMO) - 1;

    generate
        if (MAX_LOAD >= (1 << CNT_W)) begin : g_cnt_w_too_small
            $error("CNT_W too narrow for the configured delays");
        end
    endgenerate

    pwr_state_e       state, state_next;
    logic             timer_load, timer_done;
    logic [CNT_W-1:0] timer_val;
    logic             enter_active;
`ifdef LAYER_CTRL_PWR_TIMEOUT_EN
    logic             drain_timeout;
`endif

    always_comb begin
        state_next = state;
`ifdef LAYER_CTRL_PWR_TIMEOUT_EN
        drain_timeout = 1'b0;
`endif
        case (state)
            ST_OFF:     if (wakeup_req) state_next = ST_PWR_UP;
            ST_PWR_UP:  if (timer_done) state_next = ST_CLK_ON;
            ST_CLK_ON:  if (timer_done) state_next = ST_RST_REL;
            ST_RST_REL: if (timer_done) state_next = ST_ACTIVE;
            ST_ACTIVE:  if (sleep_req)  state_next = ST_DRAIN;
            ST_DRAIN: begin
                // abort outranks the drain-complete exit
                if (!sleep_req && wakeup_req) begin
                    state_next = ST_ACTIVE;
                end else if (!lc_busy) begin
                    state_next = ST_ISO_ON;
                end
`ifdef LAYER_CTRL_PWR_TIMEOUT_EN
                else if (timer_done) begin
                    state_next    = ST_ISO_ON;
                    drain_timeout = 1'b1;
                end
`endif
            end
            ST_ISO_ON:  if (timer_done) state_next = ST_RST_ON;
            ST_RST_ON:  if (timer_done) state_next = ST_PWR_DN;
            ST_PWR_DN:  if (timer_done) state_next = ST_OFF;
            default:    state_next = ST_OFF;
        endcase
    end

    always_comb begin
        timer_val = '0;
        case (state_next)
            ST_PWR_UP:  timer_val = CNT_W'(T_PWR - 1);
            ST_CLK_ON:  timer_val = CNT_W'(T_CLK - 1);
            ST_RST_REL: timer_val = CNT_W'(T_RST - 1);
            ST_ISO_ON:  timer_val = CNT_W'(T_ISO - 1);
            ST_RST_ON:  timer_val = CNT_W'(T_RST - 1);
            ST_PWR_DN:  timer_val = CNT_W'(T_PWR - 1);
`ifdef LAYER_CTRL_PWR_TIMEOUT_EN
            ST_DRAIN:   timer_val = CNT_W'(DRAIN_TMO - 1);
`endif
            default:    timer_val = '0;
        endcase
    end

    assign timer_load   = (state_next != state);
    assign enter_active = (state == ST_RST_REL) && (state_next == ST_ACTIVE);

    layer_ctrl_pwr_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // outputs are registered from state_next so they line up with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OFF;
            {lc_sleep, lc_clk_en, lc_reset, lc_isolation} <= state_outputs(ST_OFF);
            pwr_ack <= 1'b0;
        end else begin
            state <= state_next;
            {lc_sleep, lc_clk_en, lc_reset, lc_isolation} <= state_outputs(state_next);
            pwr_ack <= enter_active || ((state == ST_PWR_DN) && (state_next == ST_OFF));
        end
    end

`ifdef LAYER_CTRL_PWR_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (drain_timeout) begin
            timeout_flag <= 1'b1;
        end else if (enter_active) begin
            timeout_flag <= 1'b0;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

    assign pwr_state = state;

endmodule
